dcomp_inhibit: RTL and testbench

- Consumer end of the blitter data comparator. Takes the per-byte equality flags `dcomp_0..7` for each phrase and resolves them into per-pixel matches according to pixel size.
- Produces the byte write mask and a whole-phrase inhibit for the blitter write path.
- Pipelined behind a valid/ready handshake, with an op-level state machine (start → phrases → last → done).

---
 rtl/dcomp_inhibit_pkg.sv | 26 ++
 rtl/dcomp_pixmatch.sv | 44 ++++
 rtl/dcomp_inhibit.sv | 137 +++++++++++++
 tb/tb_dcomp_inhibit.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcomp_inhibit_pkg.sv
// ============================================================================
// Module      : dcomp_inhibit_pkg
// Description : Shared constants and state encoding for the data-compare
//               write-inhibit block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dcomp_inhibit_pkg;

   localparam int unsigned MASK_W = 8;

   localparam logic [2:0] PIX8  = 3'd3;
   localparam logic [2:0] PIX16 = 3'd4;
   localparam logic [2:0] PIX32 = 3'd5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/dcomp_pixmatch.sv
// ============================================================================
// Module      : dcomp_pixmatch
// Description : Combinational resolution of per-byte equality flags into
//               per-pixel matches, byte write mask and whole-phrase inhibit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcomp_pixmatch
   import dcomp_inhibit_pkg::*;
(
   input  logic [2:0]        pixsize,
   input  logic              dcompen,
   input  logic [MASK_W-1:0] dcomp,
   output logic [MASK_W-1:0] wr_mask,
   output logic              phr_inhibit
);

   logic [MASK_W-1:0] w_match16;
   logic [MASK_W-1:0] w_match32;
   logic [MASK_W-1:0] w_match;

   // Every byte inherits the AND of all byte flags in its own pixel.
   for (genvar b = 0; b < MASK_W; b++) begin : g_byte
      assign w_match16[b] = &dcomp[(b/2)*2 +: 2];
      assign w_match32[b] = &dcomp[(b/4)*4 +: 4];
   end

   always_comb begin
      w_match = '0;
      case (pixsize)
         PIX8:    w_match = dcomp;
         PIX16:   w_match = w_match16;
         PIX32:   w_match = w_match32;
         default: w_match = '0;
      endcase
   end

   assign wr_mask     = ~(w_match & {MASK_W{dcompen}});
   assign phr_inhibit = ~|wr_mask;

endmodule

`default_nettype wire

// File: rtl/dcomp_inhibit.sv
// ============================================================================
// Module      : dcomp_inhibit
// Description : Blitter data-compare consumer: op FSM, one-deep output
//               register behind valid/ready, optional inhibit statistics
//               (enabled by `define DCOMP_INHIBIT_STATS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcomp_inhibit
   import dcomp_inhibit_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic              sys_clk,
   input  logic              reset,
   input  logic              start,
   input  logic              dcompen,
   input  logic [2:0]        pixsize,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [MASK_W-1:0] dcomp,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [MASK_W-1:0] wr_mask,
   output logic              phr_inhibit,
   output logic              out_last,
   output logic              busy,
   output logic              done
`ifdef DCOMP_INHIBIT_STATS_EN
  ,output logic [CNT_W-1:0]  inh_count
`endif
);

   if (CNT_W < 1) begin : g_cnt_w_check
      $error("CNT_W must be at least 1");
   end

   state_t            r_state;
   state_t            w_state_next;
   logic              r_dcompen;
   logic [2:0]        r_pixsize;
   logic              r_out_valid;
   logic [MASK_W-1:0] r_wr_mask;
   logic              r_phr_inhibit;
   logic              r_out_last;
   logic [MASK_W-1:0] w_mask;
   logic              w_inh;
   logic              w_push;
   logic              w_pop;
   logic              w_start_acc;

   dcomp_pixmatch u_pixmatch (
      .pixsize     (r_pixsize),
      .dcompen     (r_dcompen),
      .dcomp       (dcomp),
      .wr_mask     (w_mask),
      .phr_inhibit (w_inh)
   );

   assign w_start_acc = (r_state == IDLE) && start;
   assign in_ready    = (r_state == RUN) && (!r_out_valid || out_ready);
   assign w_push      = in_valid && in_ready;
   assign w_pop       = r_out_valid && out_ready;

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = RUN;
         RUN:     if (w_push && in_last) w_state_next = DRAIN;
         DRAIN:   if (!r_out_valid || w_pop) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Op configuration is frozen for the whole op.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         r_dcompen <= 1'b0;
         r_pixsize <= 3'd0;
      end else if (w_start_acc) begin
         r_dcompen <= dcompen;
         r_pixsize <= pixsize;
      end
   end

   // A push takes priority over a simultaneous pop, keeping out_valid high.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         r_out_valid   <= 1'b0;
         r_wr_mask     <= '1;
         r_phr_inhibit <= 1'b0;
         r_out_last    <= 1'b0;
      end else if (w_push) begin
         r_out_valid   <= 1'b1;
         r_wr_mask     <= w_mask;
         r_phr_inhibit <= w_inh;
         r_out_last    <= in_last;
      end else if (w_pop) begin
         r_out_valid   <= 1'b0;
      end
   end

`ifdef DCOMP_INHIBIT_STATS_EN
   logic [CNT_W-1:0] r_inh_count;

   always_ff @(posedge sys_clk) begin
      if (reset || w_start_acc) begin
         r_inh_count <= '0;
      end else if (w_pop && r_phr_inhibit && (r_inh_count != '1)) begin
         r_inh_count <= r_inh_count + 1'b1;
      end
   end

   assign inh_count = r_inh_count;
`endif

   assign out_valid   = r_out_valid;
   assign wr_mask     = r_wr_mask;
   assign phr_inhibit = r_phr_inhibit;
   assign out_last    = r_out_last;
   assign busy        = (r_state != IDLE);
   assign done        = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_dcomp_inhibit.sv
// ============================================================================
// Module      : tb_dcomp_inhibit
// Description : Self-checking bench for dcomp_inhibit with a queue scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcomp_inhibit;

   logic       sys_clk = 1'b0;
   logic       reset;
   logic       start;
   logic       dcompen;
   logic [2:0] pixsize;
   logic       in_valid;
   logic       in_ready;
   logic       in_last;
   logic [7:0] dcomp;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] wr_mask;
   logic       phr_inhibit;
   logic       out_last;
   logic       busy;
   logic       done;
`ifdef DCOMP_INHIBIT_STATS_EN
   logic [15:0] inh_count;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [7:0] mask;
      logic       inh;
      logic       last;
   } exp_t;

   exp_t exp_q [$];

   dcomp_inhibit #(.CNT_W(16)) dut (
      .sys_clk     (sys_clk),
      .reset       (reset),
      .start       (start),
      .dcompen     (dcompen),
      .pixsize     (pixsize),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_last     (in_last),
      .dcomp       (dcomp),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .wr_mask     (wr_mask),
      .phr_inhibit (phr_inhibit),
      .out_last    (out_last),
      .busy        (busy),
      .done        (done)
`ifdef DCOMP_INHIBIT_STATS_EN
     ,.inh_count   (inh_count)
`endif
   );

   always #5 sys_clk = ~sys_clk;

   // Reference: walk each byte's pixel group and clear the byte if all flags set.
   function automatic logic [7:0] model_mask(input logic [2:0] ps, input logic en,
                                             input logic [7:0] d);
      int   sz;
      logic m;
      case (ps)
         3'd3:    sz = 1;
         3'd4:    sz = 2;
         3'd5:    sz = 4;
         default: sz = 0;
      endcase
      model_mask = 8'hFF;
      if (en && sz != 0) begin
         for (int i = 0; i < 8; i++) begin
            m = 1'b1;
            for (int j = 0; j < sz; j++) m = m & d[(i - (i % sz)) + j];
            if (m) model_mask[i] = 1'b0;
         end
      end
   endfunction

   task automatic start_op(input logic [2:0] ps, input logic en);
      @(negedge sys_clk);
      start   = 1'b1;
      pixsize = ps;
      dcompen = en;
      @(negedge sys_clk);
      start   = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge sys_clk);
      #1;
      checks++;
      if (wr_mask !== 8'hFF) begin
         failures++;
         $display("FAIL reset_wr_mask: got %h expected ff", wr_mask);
      end
      checks++;
      if ({out_valid, busy, in_ready, done, phr_inhibit, out_last} !== 6'b0) begin
         failures++;
         $display("FAIL reset_flags: got %b expected 000000",
                  {out_valid, busy, in_ready, done, phr_inhibit, out_last});
      end
      reset = 1'b0;
      @(negedge sys_clk);
      #1;
      checks++;
      if ({busy, in_ready, out_valid} !== 3'b000) begin
         failures++;
         $display("FAIL idle_after_reset: got %b expected 000", {busy, in_ready, out_valid});
      end
   endtask

   task automatic test_single();
      exp_t e;
      start_op(3'd3, 1'b1);
      in_valid  = 1'b1;
      dcomp     = 8'hA5;
      in_last   = 1'b1;
      out_ready = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL single_in_ready: got %b expected 1", in_ready);
      end
      exp_q.push_back(exp_t'{8'h5A, 1'b0, 1'b1});
      @(negedge sys_clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({out_valid, wr_mask, phr_inhibit, out_last} !== {1'b1, e.mask, e.inh, e.last}) begin
         failures++;
         $display("FAIL single_out: got v=%b m=%h i=%b l=%b expected v=1 m=%h i=%b l=%b",
                  out_valid, wr_mask, phr_inhibit, out_last, e.mask, e.inh, e.last);
      end
      checks++;
      if ({busy, done} !== 2'b10) begin
         failures++;
         $display("FAIL single_drain: got busy/done=%b expected 10", {busy, done});
      end
      out_ready = 1'b1;
      @(negedge sys_clk);
      #1;
      checks++;
      if ({done, out_valid, busy} !== 3'b101) begin
         failures++;
         $display("FAIL single_done_pulse: got done/ov/busy=%b expected 101",
                  {done, out_valid, busy});
      end
      out_ready = 1'b0;
      @(negedge sys_clk);
      #1;
      checks++;
      if ({done, busy} !== 2'b00) begin
         failures++;
         $display("FAIL single_done_end: got done/busy=%b expected 00", {done, busy});
      end
   endtask

   task automatic test_match();
      logic [2:0] ps_tab [0:7];
      logic       en_tab [0:7];
      logic [7:0] d_tab  [0:7];
      logic [7:0] m_tab  [0:7];
      logic [2:0] ps;
      logic       en;
      logic [7:0] d;
      logic [7:0] m;
      exp_t       e;
      ps_tab = '{3'd4, 3'd5, 3'd5, 3'd5, 3'd3, 3'd4, 3'd6, 3'd4};
      en_tab = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      d_tab  = '{8'h37, 8'hF7, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hC3};
      m_tab  = '{8'hCC, 8'h0F, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h3C};
      for (int k = 0; k < 14; k++) begin
         if (k < 8) begin
            ps = ps_tab[k]; en = en_tab[k]; d = d_tab[k]; m = m_tab[k];
         end else begin
            ps = 3'($urandom_range(3, 5));
            en = 1'($urandom_range(0, 1));
            d  = 8'($urandom_range(0, 255)) | 8'h3C;
            m  = model_mask(ps, en, d);
         end
         start_op(ps, en);
         in_valid  = 1'b1;
         dcomp     = d;
         in_last   = 1'b1;
         out_ready = 1'b1;
         exp_q.push_back(exp_t'{m, (m == 8'h00), 1'b1});
         @(negedge sys_clk);
         in_valid = 1'b0;
         in_last  = 1'b0;
         #1;
         e = exp_q.pop_front();
         checks++;
         if ({out_valid, wr_mask, phr_inhibit, out_last} !== {1'b1, e.mask, e.inh, e.last}) begin
            failures++;
            $display("FAIL match_%0d ps=%0d en=%b d=%h: got v=%b m=%h i=%b expected v=1 m=%h i=%b",
                     k, ps, en, d, out_valid, wr_mask, phr_inhibit, e.mask, e.inh);
         end
         @(negedge sys_clk);
         #1;
         checks++;
         if (done !== 1'b1) begin
            failures++;
            $display("FAIL match_done_%0d: got %b expected 1", k, done);
         end
      end
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [7:0] d_tab [0:3];
      bit         pat   [0:3];
      int         idx   = 0;
      int         pops  = 0;
      logic       stalled = 1'b0;
      logic [10:0] prev = '0;
      exp_t       e;
      d_tab = '{8'h03, 8'h0C, 8'h30, 8'hC0};
      pat   = '{1'b1, 1'b0, 1'b1, 1'b1};
      start_op(3'd4, 1'b1);
      for (int cyc = 0; cyc < 30; cyc++) begin
         if (cyc > 0) @(negedge sys_clk);
         in_valid  = (idx < 4);
         dcomp     = d_tab[idx % 4];
         in_last   = (idx == 3);
         out_ready = (cyc < 4) ? pat[cyc] : 1'b1;
         #1;
         if (stalled) begin
            checks++;
            if ({out_valid, wr_mask, phr_inhibit, out_last} !== prev) begin
               failures++;
               $display("FAIL b2b_stable: got %h expected %h",
                        {out_valid, wr_mask, phr_inhibit, out_last}, prev);
            end
         end
         if (out_valid && !out_ready) begin
            checks++;
            if (in_ready !== 1'b0) begin
               failures++;
               $display("FAIL b2b_stall_ready: got %b expected 0", in_ready);
            end
         end
         if (out_valid && out_ready) begin
            pops++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL b2b_extra: got phrase m=%h expected none", wr_mask);
            end else begin
               e = exp_q.pop_front();
               if ({wr_mask, phr_inhibit, out_last} !== {e.mask, e.inh, e.last}) begin
                  failures++;
                  $display("FAIL b2b_out: got m=%h i=%b l=%b expected m=%h i=%b l=%b",
                           wr_mask, phr_inhibit, out_last, e.mask, e.inh, e.last);
               end
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(exp_t'{model_mask(3'd4, 1'b1, dcomp), 1'b0, in_last});
            idx++;
         end
         stalled = out_valid && !out_ready;
         prev    = {out_valid, wr_mask, phr_inhibit, out_last};
         if (idx == 4 && exp_q.size() == 0) break;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      checks++;
      if (pops !== 4) begin
         failures++;
         $display("FAIL b2b_count: got %0d phrases expected 4", pops);
      end
      @(negedge sys_clk);
      #1;
      checks++;
      if ({done, out_valid} !== 2'b10) begin
         failures++;
         $display("FAIL b2b_done: got done/ov=%b expected 10", {done, out_valid});
      end
      out_ready = 1'b0;
      exp_q.delete();
   endtask

`ifdef DCOMP_INHIBIT_STATS_EN
   task automatic test_stats();
      logic [7:0] d_tab [0:3];
      d_tab = '{8'hFF, 8'hFF, 8'h0F, 8'hFF};
      start_op(3'd5, 1'b1);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         dcomp    = d_tab[i];
         in_last  = (i == 3);
         @(negedge sys_clk);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(negedge sys_clk);
      #1;
      checks++;
      if (inh_count !== 16'd3) begin
         failures++;
         $display("FAIL stats_count: got %0d expected 3", inh_count);
      end
      start_op(3'd3, 1'b1);
      #1;
      checks++;
      if (inh_count !== 16'd0) begin
         failures++;
         $display("FAIL stats_clear: got %0d expected 0", inh_count);
      end
      in_valid = 1'b1;
      dcomp    = 8'h00;
      in_last  = 1'b1;
      @(negedge sys_clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (2) @(negedge sys_clk);
      out_ready = 1'b0;
   endtask
`endif

   task automatic test_reset_midop();
      logic seen = 1'b0;
      start_op(3'd3, 1'b1);
      in_valid  = 1'b1;
      dcomp     = 8'h0F;
      in_last   = 1'b0;
      out_ready = 1'b0;
      @(negedge sys_clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if ({out_valid, busy} !== 2'b11) begin
         failures++;
         $display("FAIL midop_held: got ov/busy=%b expected 11", {out_valid, busy});
      end
      reset = 1'b1;
      @(negedge sys_clk);
      reset = 1'b0;
      #1;
      checks++;
      if ({out_valid, busy, done, wr_mask} !== {3'b000, 8'hFF}) begin
         failures++;
         $display("FAIL midop_reset: got ov/busy/done=%b m=%h expected 000 m=ff",
                  {out_valid, busy, done}, wr_mask);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge sys_clk);
         if (done) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL midop_no_done: got done pulse expected none");
      end
      in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL idle_in_ready: got %b expected 0", in_ready);
      end
      @(negedge sys_clk);
      #1;
      checks++;
      if ({out_valid, busy} !== 2'b00) begin
         failures++;
         $display("FAIL idle_ignore: got ov/busy=%b expected 00", {out_valid, busy});
      end
      in_valid = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      dcompen   = 1'b0;
      pixsize   = 3'd0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      dcomp     = 8'h00;
      out_ready = 1'b0;
      test_reset();
      test_single();
      test_match();
      test_back_to_back();
`ifdef DCOMP_INHIBIT_STATS_EN
      test_stats();
`endif
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
